dac_spi_streamer: RTL
=====================

// Module: dac_spi_streamer
// PURPOSE
//  Consumes the 12-bit sample stream produced by signal_generator and serialises each sample to an
//  external SPI DAC through user io_out pads. Sits directly downstream of signal_generator inside
//  user_analog_project_wrapper. Buffers samples in a small FIFO. Frames each sample as {CMD,sample}.
//  Reports stream underrun and a count of frames sent.
// PARAMETERS
//  DATA_W   12       sample width (bits)
//  CMD_W    4        command-prefix width; FRAME_W = CMD_W+DATA_W (16 by default)
//  DAC_CMD  4'b0011  command nibble prepended to every sample (write-and-update, channel A)
//  CLK_DIV  2        wb_clk_i cycles per SCLK half-period; legal range >=1
//  FIFO_D   4        sample FIFO depth; power of 2, >=2
// PORTS
//  wb_clk_i        in   1       single clock domain
//  wb_rst_ni       in   1       asynchronous reset, active-low
//  enable_i        in   1       stream enable
//  clr_i           in   1       synchronous clear of underrun_o and frame_cnt_o
//  sample_i        in   DATA_W  sample from signal_generator
//  sample_valid_i  in   1       sample_i is valid
//  sample_ready_o  out  1       FIFO can accept a sample
//  dac_sclk_o      out  1       SPI clock; idles low (mode 0)
//  dac_cs_n_o      out  1       SPI chip select, active-low
//  dac_mosi_o      out  1       SPI data, MSB first
//  dac_ldac_n_o    out  1       DAC load strobe, active-low; present only with DAC_LDAC_EN
//  busy_o          out  1       FSM not in IDLE
//  underrun_o      out  1       sticky: stream ran dry mid-stream
//  frame_cnt_o     out  16      frames completed; wraps 0xFFFF->0x0000
// BEHAVIOUR
//  Reset (async): FIFO empty; FSM=IDLE; cs_n=1, sclk=0, mosi=0, ldac_n=1; ready=0; busy=0; underrun=0; cnt=0.
//  Handshake: push on sample_valid_i & sample_ready_o. sample_ready_o = enable_i & !full.
//   A push while full is impossible. A pop in the same cycle does not free that slot this cycle.
//  enable_i low: the in-flight frame completes normally; FIFO is flushed the cycle after FSM reaches IDLE.
//  FSM IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE. Each phase is timed by a divider tick every CLK_DIV cycles.
//   IDLE : leave when enable_i & !empty. Pop the FIFO head into a FRAME_W shift register {DAC_CMD,sample}.
//   SETUP: cs_n=0, sclk=0, mosi=frame MSB; lasts CLK_DIV cycles.
//   SHIFT: per bit, sclk low CLK_DIV cycles then high CLK_DIV cycles. mosi updates only at the start
//          of the low half. Lasts 2*FRAME_W*CLK_DIV cycles.
//   HOLD : sclk=0, cs_n=0; CLK_DIV cycles. frame_cnt_o increments on HOLD->GAP.
//   GAP  : cs_n=1; CLK_DIV cycles. At GAP exit, underrun_o sets if enable_i & FIFO empty.
//  Latency: sample pushed into an empty FIFO in cycle N -> cs_n falls in cycle N+2.
//   cs_n low for (2*FRAME_W+2)*CLK_DIV cycles (68 at defaults). Back-to-back frame period (2*FRAME_W+3)*CLK_DIV.
//  clr_i is synchronous; clears underrun_o/frame_cnt_o. clr_i has priority over a same-cycle set/increment.
//  Reset mid-frame: cs_n rises immediately (async). The partial frame is discarded.
// CONFIGURATION
//  DAC_LDAC_EN defined: dac_ldac_n_o exists and is low for the whole GAP phase (CLK_DIV cycles) after
//   every frame; the DAC latches on LDAC.
//  DAC_LDAC_EN undefined: the port is absent and the DAC updates on the cs_n rising edge. Timing is unchanged.
// STRUCTURE
//  dac_spi_pkg: state enum (IDLE/SETUP/SHIFT/HOLD/GAP), FRAME_W localparam, default DAC_CMD.
//  Sub-module sample_fifo: registered synchronous FIFO, DATA_W x FIFO_D, with full/empty/flush.
//  FSM, divider, bit counter and shift register live in dac_spi_streamer.
// TESTING
//  Single sample 0xABC, defaults -> mosi captured on 16 sclk rises = 0x3ABC; cs_n low 68 cycles; frame_cnt=1.
//  Push 5 samples back-to-back, FIFO_D=4 -> ready low while 4 held. All 5 frames emitted in order.
//   Frame spacing 70 cycles; no underrun before last frame.
//  Stream of 2 samples then stop, enable_i high -> underrun_o=1 after 2nd GAP; clr_i -> underrun_o=0, frame_cnt=0.
//  Deassert enable_i during bit 7 of a frame -> frame completes; FIFO flushed; ready low; busy low after GAP.
//  Assert wb_rst_ni low mid-SHIFT -> cs_n=1, sclk=0 same cycle; after release, no residual frame.
//  DAC_LDAC_EN build, CLK_DIV=3 -> ldac_n low exactly 3 cycles right after each cs_n rise. frame_cnt wraps
//   from 0xFFFF (preloaded by forcing) to 0.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// Shared types and defaults for the SPI DAC streamer.
// Build macro DAC_LDAC_EN (see dac_spi_streamer) adds the LDAC strobe.
package dac_spi_pkg;

   localparam int                DEF_DATA_W  = 12;
   localparam int                DEF_CMD_W   = 4;
   localparam int                FRAME_W     = DEF_CMD_W + DEF_DATA_W;
   localparam logic [DEF_CMD_W-1:0] DEF_DAC_CMD = 4'b0011;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

endpackage

// File: rtl/dac_spi_streamer_sample_fifo.sv
// Registered synchronous sample FIFO with occupancy-based full/empty and flush.
// Head data reads straight from the storage registers.
module sample_fifo #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 4
) (
   input  logic              gclk,
   input  logic              grst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge gclk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Depth is a power of two, so the pointers wrap on their own.
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dac_spi_streamer.sv
// Serialises buffered 12-bit samples to an SPI DAC as {CMD,sample}, mode 0, MSB first.
// Define DAC_LDAC_EN to add dac_ldac_n_o, pulsed low for the GAP phase after every frame.
module dac_spi_streamer
   import dac_spi_pkg::*;
#(
   parameter int                DATA_W  = DEF_DATA_W,
   parameter int                CMD_W   = DEF_CMD_W,
   parameter logic [CMD_W-1:0]  DAC_CMD = DEF_DAC_CMD,
   parameter int                CLK_DIV = 2,
   parameter int                FIFO_D  = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              enable_i,
   input  logic              clr_i,
   input  logic [DATA_W-1:0] sample_i,
   input  logic              sample_valid_i,
   output logic              sample_ready_o,
   output logic              dac_sclk_o,
   output logic              dac_cs_n_o,
   output logic              dac_mosi_o,
`ifdef DAC_LDAC_EN
   output logic              dac_ldac_n_o,
`endif
   output logic              busy_o,
   output logic              underrun_o,
   output logic [15:0]       frame_cnt_o
);

   localparam int FW    = CMD_W + DATA_W;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (FW > 1) ? $clog2(FW) : 1;

   state_t            state;
   logic [DIV_W-1:0]  div;
   logic              tick;
   logic              phase_hi;
   logic [BIT_W-1:0]  bit_idx;
   logic [FW-1:0]     sreg;
   logic [FW-1:0]     frame;
   logic              armed;
   logic              sclk;
   logic              cs_n;
   logic              mosi;
   logic              underrun;
   logic [15:0]       frame_cnt;
`ifdef DAC_LDAC_EN
   logic              ldac_n;
`endif

   logic              push;
   logic              pop;
   logic              flush;
   logic              full;
   logic              empty;
   logic [DATA_W-1:0] head;
   logic              start;

   // armed keeps ready low until the first clock after reset release.
   assign sample_ready_o = armed & enable_i & ~full;
   assign push           = sample_valid_i & sample_ready_o;
   assign tick           = (div == DIV_W'(CLK_DIV - 1));
   assign start          = enable_i & ~empty &
                           ((state == IDLE) | ((state == GAP) & tick));
   assign pop            = start;
   assign flush          = (state == IDLE) & ~enable_i;
   assign frame          = {DAC_CMD, head};

   sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_D)
   ) u_fifo (
      .gclk   (wb_clk_i),
      .grst_n (wb_rst_ni),
      .push   (push),
      .pop    (pop),
      .flush  (flush),
      .din    (sample_i),
      .dout   (head),
      .full   (full),
      .empty  (empty)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state     <= IDLE;
         div       <= '0;
         phase_hi  <= 1'b0;
         bit_idx   <= '0;
         sreg      <= '0;
         armed     <= 1'b0;
         sclk      <= 1'b0;
         cs_n      <= 1'b1;
         mosi      <= 1'b0;
         underrun  <= 1'b0;
         frame_cnt <= '0;
`ifdef DAC_LDAC_EN
         ldac_n    <= 1'b1;
`endif
      end else begin
         armed <= 1'b1;
         div   <= ((state == IDLE) || tick) ? '0 : div + 1'b1;

         unique case (state)
            IDLE: ;
            SETUP: begin
               if (tick) begin
                  state    <= SHIFT;
                  phase_hi <= 1'b0;
                  bit_idx  <= '0;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (!phase_hi) begin
                     sclk     <= 1'b1;
                     phase_hi <= 1'b1;
                  end else begin
                     // falling edge opens the next bit's low half
                     sclk     <= 1'b0;
                     phase_hi <= 1'b0;
                     if (bit_idx == BIT_W'(FW - 1)) begin
                        state <= HOLD;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                        sreg    <= sreg << 1;
                        mosi    <= sreg[FW-2];
                     end
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  state     <= GAP;
                  cs_n      <= 1'b1;
                  mosi      <= 1'b0;
                  frame_cnt <= frame_cnt + 16'd1;
`ifdef DAC_LDAC_EN
                  ldac_n    <= 1'b0;
`endif
               end
            end
            GAP: begin
               if (tick) begin
                  state <= IDLE;
                  if (enable_i && empty) underrun <= 1'b1;
`ifdef DAC_LDAC_EN
                  ldac_n <= 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase

         // A waiting sample skips IDLE so back-to-back frames stay gapless.
         if (start) begin
            state <= SETUP;
            sreg  <= frame;
            mosi  <= frame[FW-1];
            cs_n  <= 1'b0;
            sclk  <= 1'b0;
         end

         if (clr_i) begin
            underrun  <= 1'b0;
            frame_cnt <= '0;
         end
      end
   end

   assign dac_sclk_o  = sclk;
   assign dac_cs_n_o  = cs_n;
   assign dac_mosi_o  = mosi;
   assign busy_o      = (state != IDLE);
   assign underrun_o  = underrun;
   assign frame_cnt_o = frame_cnt;
`ifdef DAC_LDAC_EN
   assign dac_ldac_n_o = ldac_n;
`endif

endmodule
